// File: rtl/seg7_scan_port_if.sv
// Processor-side register bus for the seven-segment scan port.
// The master drives the request; the slave returns registered read data.
interface seg7_scan_port_if;
  logic        cs;
  logic        wr;
  logic        rd_en;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (output cs, output wr, output rd_en, output addr, output wdata, input rdata);
  modport slave  (input cs, input wr, input rd_en, input addr, input wdata, output rdata);
endinterface

// File: rtl/seg7_scan_port.sv
// Memory-mapped seven-segment display peripheral: per-digit registers, a control word,
// and a prescaled, guard-blanked, active-low multiplexed scan with registered readback.
module seg7_scan_port #(
  parameter int NDIG     = 8,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 500
) (
  input  logic            Clock,
  input  logic            Resetn,
  seg7_scan_port_if.slave bus,
  output logic [7:0]      seg_n,
  output logic [NDIG-1:0] dig_n
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] P_GUARD = PW'(GUARD);
  localparam logic [IW-1:0] I_LAST  = IW'(NDIG - 1);
  localparam logic [15:0]   DIG_MASK  = 16'h80FF;
  localparam logic [15:0]   CTRL_MASK = 16'hFF01;
  localparam logic [3:0]    CTRL_ADDR = 4'b1000;

  logic [15:0]     digit_q [NDIG];
  logic [15:0]     digit_d [NDIG];
  logic [15:0]     ctrl_q, ctrl_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [PW-1:0]   p_q, p_d;
  logic [IW-1:0]   i_q, i_d;
  logic [7:0]      seg_q, seg_d;
  logic [NDIG-1:0] dig_q, dig_d;

  logic            wr_en;
  logic [15:0]     rd_val;
  logic [15:0]     cur_digit;
  logic [7:0]      blank_mask;
  logic [6:0]      pattern_n;

  // Active-low g..a pattern for a hex nibble
  function automatic logic [6:0] hex_seg_n(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    wr_en  = bus.cs & bus.wr;
    rd_val = 16'h0000;
    for (int k = 0; k < NDIG; k++) begin
      rd_val     = (bus.addr == 4'(k)) ? digit_q[k] : rd_val;
      digit_d[k] = (wr_en && (bus.addr == 4'(k))) ? (bus.wdata & DIG_MASK) : digit_q[k];
    end
    rd_val  = (bus.addr == CTRL_ADDR) ? ctrl_q : rd_val;
    ctrl_d  = (wr_en && (bus.addr == CTRL_ADDR)) ? (bus.wdata & CTRL_MASK) : ctrl_q;
    rdata_d = (bus.cs && bus.rd_en) ? rd_val : rdata_q;
  end

  // Scan counters freeze the digit index while disabled so re-enable resumes in place
  always_comb begin
    p_d = p_q;
    i_d = i_q;
    if (ctrl_q[0]) begin
      if (p_q == P_LAST) begin
        p_d = '0;
        i_d = (i_q == I_LAST) ? '0 : i_q + IW'(1);
      end else begin
        p_d = p_q + PW'(1);
        i_d = i_q;
      end
    end else begin
      p_d = '0;
      i_d = i_q;
    end
  end

  always_comb begin
    cur_digit = 16'h0000;
    for (int k = 0; k < NDIG; k++) begin
      cur_digit = (i_q == IW'(k)) ? digit_q[k] : cur_digit;
    end
    blank_mask = ctrl_q[15:8];
    pattern_n  = cur_digit[15] ? hex_seg_n(cur_digit[3:0]) : ~cur_digit[6:0];
    seg_d      = 8'hFF;
    dig_d      = '1;
    if (!ctrl_q[0] || (p_q < P_GUARD) || blank_mask[3'(i_q)]) begin
      seg_d = 8'hFF;
      dig_d = '1;
    end else begin
      seg_d = {~cur_digit[7], pattern_n};
      dig_d = ~(NDIG'(1) << i_q);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      for (int k = 0; k < NDIG; k++) begin
        digit_q[k] <= 16'h0000;
      end
      ctrl_q  <= 16'h0001;
      rdata_q <= 16'h0000;
      p_q     <= '0;
      i_q     <= '0;
      seg_q   <= 8'hFF;
      dig_q   <= '1;
    end else begin
      for (int k = 0; k < NDIG; k++) begin
        digit_q[k] <= digit_d[k];
      end
      ctrl_q  <= ctrl_d;
      rdata_q <= rdata_d;
      p_q     <= p_d;
      i_q     <= i_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign seg_n     = seg_q;
  assign dig_n     = dig_q;

endmodule

// File: tb/tb_seg7_scan_port.sv
// Self-checking bench for seg7_scan_port: directed scenarios plus random traffic,
// compared each cycle against a slot-arithmetic reference model.
module tb_seg7_scan_port;
  localparam int NDIG = 8;
  localparam int PS   = 4;
  localparam int GD   = 1;

  logic           Clock = 1'b0;
  logic           Resetn;
  logic [7:0]     seg_n;
  logic [NDIG-1:0] dig_n;

  seg7_scan_port_if bus ();

  seg7_scan_port #(.NDIG(NDIG), .PRESCALE(PS), .GUARD(GD)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus),
    .seg_n  (seg_n),
    .dig_n  (dig_n)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time since (re)enable gives slot and phase directly
  logic [15:0] m_dig [NDIG];
  logic [15:0] m_ctrl;
  logic [15:0] m_rd;
  int          m_t;
  int          m_i0;
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_idx();
    return (m_i0 + m_t / PS) % NDIG;
  endfunction

  function automatic int m_phase();
    return m_t % PS;
  endfunction

  function automatic logic [15:0] m_read(input logic [3:0] a);
    if (a[3] == 1'b0) return m_dig[a[2:0]];
    if (a == 4'b1000) return m_ctrl;
    return 16'h0000;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NDIG; k++) m_dig[k] = 16'h0000;
    m_ctrl = 16'h0001;
    m_rd   = 16'h0000;
    m_t    = 0;
    m_i0   = 0;
  endtask

  // One clock: predict from pre-edge model state, advance model, then compare
  task automatic step();
    logic [7:0]      es;
    logic [NDIG-1:0] ed;
    logic [15:0]     w;
    int              mi;
    es = 8'hFF;
    ed = '1;
    if (!Resetn) begin
      m_reset();
    end else begin
      mi = m_idx();
      w  = m_dig[mi];
      if (m_ctrl[0] && (m_phase() >= GD) && !m_ctrl[8 + mi]) begin
        ed = ~(NDIG'(1) << mi);
        es = {~w[7], (w[15] ? hex_tab[w[3:0]] : ~w[6:0])};
      end
      if (bus.cs && bus.rd_en) m_rd = m_read(bus.addr);
      if (m_ctrl[0]) begin
        m_t = m_t + 1;
      end else begin
        m_i0 = mi;
        m_t  = 0;
      end
      if (bus.cs && bus.wr) begin
        if (bus.addr[3] == 1'b0) m_dig[bus.addr[2:0]] = bus.wdata & 16'h80FF;
        else if (bus.addr == 4'b1000) m_ctrl = bus.wdata & 16'hFF01;
      end
    end
    @(posedge Clock);
    @(negedge Clock);
    check("seg_n", 32'(seg_n), 32'(es));
    check("dig_n", 32'(dig_n), 32'(ed));
    check("rdata", 32'(bus.rdata), 32'(m_rd));
  endtask

  task automatic drive(input logic cs, input logic wr, input logic rd,
                       input logic [3:0] a, input logic [15:0] d);
    bus.cs    = cs;
    bus.wr    = wr;
    bus.rd_en = rd;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int  hi;
    bit  found;
    logic [NDIG-1:0] exp_d;
    m_reset();
    Resetn = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'h0, 16'hFFFF);
    step();
    step();
    check("rst_seg", 32'(seg_n), 32'h0000_00FF);
    check("rst_dig", 32'(dig_n), 32'h0000_00FF);
    check("rst_rdata", 32'(bus.rdata), 32'h0000_0000);

    // Release reset with write+read of digit 0: read sees the discarded pre-reset write as 0
    Resetn = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 4'h0, 16'h8005);
    step();
    check("rst_discard", 32'(bus.rdata), 32'h0000_0000);
    check("hex_guard", 32'(dig_n), 32'h0000_00FF);
    idle(0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("hex_dig", 32'(dig_n), 32'h0000_00FE);
      check("hex_seg", 32'(seg_n), 32'h0000_0092);
    end
    drive(1'b1, 1'b0, 1'b1, 4'h0, 16'h0000);
    step();
    check("hex_read", 32'(bus.rdata), 32'h0000_8005);

    // Raw mode with dp on digit 7, then wrap to digit 0
    drive(1'b1, 1'b1, 1'b0, 4'h7, 16'h00FF);
    step();
    idle(0);
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      if (dig_n == 8'h7F) found = 1'b1;
      else step();
    end
    check("raw_found", 32'(found), 32'h1);
    check("raw_seg", 32'(seg_n), 32'h0000_0000);
    for (int k = 0; k < 4; k++) step();
    check("wrap_dig", 32'(dig_n), 32'h0000_00FE);

    // Blank mask on digit 1
    drive(1'b1, 1'b1, 1'b0, 4'h1, 16'h8001);
    step();
    drive(1'b1, 1'b1, 1'b0, 4'b1000, 16'h0201);
    step();
    idle(0);
    for (int k = 0; k < 64 && !(m_idx() == 1 && m_phase() == 2); k++) step();
    step();
    check("blank_dig", 32'(dig_n), 32'h0000_00FF);

    // Disable, hold, re-enable
    drive(1'b1, 1'b1, 1'b0, 4'b1000, 16'h0000);
    step();
    idle(1);
    check("dis_dig", 32'(dig_n), 32'h0000_00FF);
    check("dis_seg", 32'(seg_n), 32'h0000_00FF);
    hi = m_idx();
    idle(5);
    drive(1'b1, 1'b1, 1'b0, 4'b1000, 16'h0001);
    step();
    idle(1);
    check("reen_guard", 32'(dig_n), 32'h0000_00FF);
    step();
    exp_d = ~(NDIG'(1) << hi);
    check("reen_dig", 32'(dig_n), 32'(exp_d));

    // Same-cycle read and write
    drive(1'b1, 1'b1, 1'b0, 4'h3, 16'h0001);
    step();
    drive(1'b1, 1'b1, 1'b1, 4'h3, 16'h8009);
    step();
    check("rw_old", 32'(bus.rdata), 32'h0000_0001);
    drive(1'b1, 1'b0, 1'b1, 4'h3, 16'h0000);
    step();
    check("rw_new", 32'(bus.rdata), 32'h0000_8009);

    // Unmapped address
    drive(1'b1, 1'b1, 1'b0, 4'b1011, 16'hFFFF);
    step();
    drive(1'b1, 1'b0, 1'b1, 4'b1011, 16'h0000);
    step();
    check("unmap_read", 32'(bus.rdata), 32'h0000_0000);
    drive(1'b1, 1'b0, 1'b1, 4'b1000, 16'h0000);
    step();
    check("unmap_ctrl", 32'(bus.rdata), 32'h0000_0001);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [15:0] d;
      r = $urandom_range(0, 99);
      d = 16'($urandom);
      Resetn = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)), d);
      if (r < 2) begin
        Resetn = 1'b0;
        bus.cs = 1'($urandom);
        bus.wr = 1'($urandom);
      end else if (r < 6) begin
        d[0] = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
        drive(1'b1, 1'b1, 1'($urandom), 4'b1000, d);
      end else if (r < 16) begin
        drive(1'b1, 1'b1, 1'($urandom), bus.addr, d);
      end else if (r < 26) begin
        drive(1'b1, 1'($urandom), 1'b1, bus.addr, d);
      end else if (r < 30) begin
        drive(1'b0, 1'b1, 1'b1, bus.addr, d);
      end else begin
        drive(1'b0, 1'b0, 1'b0, bus.addr, d);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan_port.md
Name: seg7_scan_port

Overview:
- Memory-mapped seven-segment display peripheral on the processor's data bus, downstream of the processor's ADDR/DOUT/W registers.
- It is selected by the chipselect decode for ADDR[15:12]=4'h2.
- It stores one word per digit plus a control word.
- It drives a time-multiplexed, active-low segment/digit interface with a prescaled scan and an anti-ghost blanking guard, and supports registered readback onto the processor's DIN path.

Parameters:
- NDIG, 8: number of digits scanned (1..8); digit registers beyond NDIG-1 are not implemented.
- PRESCALE, 50000: Clock cycles per digit slot (>=2).
- GUARD, 500: cycles at the start of each slot during which all digits are off (0 <= GUARD < PRESCALE).

Ports:
- Clock  in  1  system clock, rising edge
- Resetn  in  1  synchronous, active-low reset
- cs  in  1  chip select from address decode (ADDR[15:12]=4'h2)
- wr  in  1  write strobe (processor W), qualified by cs
- rd_en  in  1  read request, qualified by cs
- addr  in  4  ADDR[3:0]
- wdata  in  16  DOUT
- rdata  out  16  registered readback
- seg_n  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- dig_n  out  NDIG  digit enables, active-low, one-hot-low

Behaviour:
- Reset: Resetn and Clock are as stated in Ports (synchronous, active-low). Resetn=0 at an edge forces the following, overriding everything including a mid-slot scan or a simultaneous write:
  - all digit regs = 16'h0000
  - CTRL = 16'h0001
  - prescaler p = 0, index i = 0
  - rdata = 16'h0000, seg_n = 8'hFF, dig_n = all ones
- Register map:
  - addr[3]=0 selects digit reg addr[2:0]; indices >= NDIG are ignored on write and read as 0.
  - addr=4'b1000 is CTRL: bit0 = scan enable; bits[15:8] = blank mask (bit k blanks digit k).
  - Other addr[3]=1 addresses are ignored on write and read as 0.
- Digit word format:
  - [15] hex mode; [7] dp (1 = lit).
  - Raw mode ([15]=0): [6:0] = active-high segments g..a.
  - Hex mode: [3:0] is a nibble.
  - Only bits 15, 7, 6:0 are stored; all other bits read 0.
  - CTRL stores bits 15:8 and 0 only.
- Write: cs&wr at an edge updates the addressed register at that edge; zero latency.
- Read: cs&rd_en at edge N loads rdata with the pre-edge contents of the addressed register, visible after edge N. rdata holds otherwise. On a same-cycle write and read of one address, rdata returns the old value.
- Scan (enable=1):
  - p increments every cycle. At p=PRESCALE-1, p wraps to 0 and i advances; i wraps NDIG-1 -> 0.
- Output registers load each edge from pre-edge p, i and register contents, so outputs lag the counters by one cycle:
  - If p<GUARD, or blank mask bit i=1: dig_n = all ones, seg_n = 8'hFF.
  - Otherwise: dig_n bit i = 0 and all others 1; seg_n = {~dp, ~pattern}, where pattern is the raw segments or the hex decode.
- Hex decode, shown as active-low g..a:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Scan disable (enable=0): p is cleared to 0 and i holds. From the next edge, dig_n = all ones and seg_n = 8'hFF. On re-enable the scan resumes at the held i with p=0, so a full guard interval precedes display.
- Writing the currently displayed digit: the new pattern appears on seg_n one edge after the write edge; no partial or mixed pattern.
- Counter widths are sized for PRESCALE-1 and NDIG-1; no overflow beyond the wrap points.

Test Plan:
- Reset: hold Resetn=0 for 2 edges mid-scan with cs&wr active -> all regs 0, rdata=0000, seg_n=FF, dig_n=FF; the write is discarded.
- Hex write and readback (PRESCALE=4, GUARD=1, NDIG=8):
  - Stimulus: write addr 0 = 16'h8005.
  - Required: in digit 0's slot, dig_n=FE and seg_n=8'h92 for 3 cycles, preceded by 1 cycle of dig_n=FF.
  - Then read addr 0 -> rdata=8005 the next cycle.
- Raw mode, dp and scan wrap:
  - Stimulus: write digit 7 = 16'h00FF.
  - Required: seg_n=8'h00 with dig_n=7F; the next slot shows dig_n=FE, i.e. i wraps 7->0 after exactly 4 cycles.
- Blank mask and disable:
  - Write CTRL=16'h0201 -> digit 1's slot shows dig_n=FF.
  - Write CTRL=0 -> all outputs off from the next edge with i held.
  - Re-enable -> the held digit reappears after 1 guard cycle.
- Same-cycle read and write:
  - Stimulus: digit 3 holds 0001; write 16'h8009 and read addr 3 in the same cycle.
  - Required: rdata=0001, and a subsequent read returns 8009.
- Unmapped addresses: write addr 4'b1011 = FFFF -> no register changes; read addr 4'b1011 -> rdata=0000.
